// File: rtl/q9_sweep_ctrl_if.sv
// Handshake and result bundle between the sweep sequencer and its user.
// The slave side is the sequencer; the master side drives start/abort and the function output.
interface q9_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic [15:0] truth_table;

    modport slave (
        input  start, abort, f_in,
        output a, b, c, d, busy, done, pass, mismatch_cnt, first_fail, truth_table
    );

    modport master (
        output start, abort, f_in,
        input  a, b, c, d, busy, done, pass, mismatch_cnt, first_fail, truth_table
    );
endinterface

// File: rtl/q9_sweep_ctrl.sv
// Self-test sequencer: walks {a,b,c,d} through 0..15, samples f_in after a settle
// time and compares the captured truth table against a golden signature.
//
// state | meaning
// IDLE  | waiting for start; last results held
// RUN   | driving vector idx, counting settle cycles
// DONE  | one-cycle done pulse, then back to IDLE
module q9_sweep_ctrl #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    q9_sweep_ctrl_if.slave  sif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state,    state_nxt;
    logic [7:0]  cnt,      cnt_nxt;
    logic [3:0]  idx,      idx_nxt;
    logic [3:0]  vec,      vec_nxt;
    logic        busy,     busy_nxt;
    logic        done,     done_nxt;
    logic        pass,     pass_nxt;
    logic [4:0]  mcnt,     mcnt_nxt;
    logic [3:0]  ffail,    ffail_nxt;
    logic [15:0] tt,       tt_nxt;
    logic        miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            vec   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
            mcnt  <= '0;
            ffail <= '0;
            tt    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            vec   <= vec_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            pass  <= pass_nxt;
            mcnt  <= mcnt_nxt;
            ffail <= ffail_nxt;
            tt    <= tt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        vec_nxt   = vec;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        pass_nxt  = pass;
        mcnt_nxt  = mcnt;
        ffail_nxt = ffail;
        tt_nxt    = tt;
        miss      = (sif.f_in != EXPECTED[idx]);

        unique case (state)
            IDLE: begin
                if (sif.start && !sif.abort) begin
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    vec_nxt   = '0;
                    tt_nxt    = '0;
                    mcnt_nxt  = '0;
                    ffail_nxt = '0;
                    pass_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (sif.abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    vec_nxt   = '0;
                    pass_nxt  = 1'b0;
                end else if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + 8'd1;
                end else begin
                    tt_nxt[idx] = sif.f_in;
                    if (miss) begin
                        mcnt_nxt = mcnt + 5'd1;
                        if (mcnt == 5'd0) ffail_nxt = idx;
                    end
                    cnt_nxt = '0;
                    if (idx != 4'd15) begin
                        idx_nxt = idx + 4'd1;
                        vec_nxt = idx + 4'd1;
                    end else begin
                        // pass must include the verdict of this final sample
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        vec_nxt   = '0;
                        pass_nxt  = (mcnt == 5'd0) && !miss;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sif.a            = vec[3];
    assign sif.b            = vec[2];
    assign sif.c            = vec[1];
    assign sif.d            = vec[0];
    assign sif.busy         = busy;
    assign sif.done         = done;
    assign sif.pass         = pass;
    assign sif.mismatch_cnt = mcnt;
    assign sif.first_fail   = ffail;
    assign sif.truth_table  = tt;

endmodule

// File: tb/tb_q9_sweep_ctrl.sv
// Directed bench for q9_sweep_ctrl: three instances with settle times 2, 1 and 5,
// a table of full sweeps plus hand sequences for abort, start/abort collision and async reset.
module tb_q9_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flt = 1'b0;
    logic st [3];
    logic ab [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    q9_sweep_ctrl_if if0 ();
    q9_sweep_ctrl_if if1 ();
    q9_sweep_ctrl_if if2 ();

    q9_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(16'hF888)) dut0 (.clk(clk), .rst(rst), .sif(if0));
    q9_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(16'hF888)) dut1 (.clk(clk), .rst(rst), .sif(if1));
    q9_sweep_ctrl #(.SETTLE_CYCLES(5), .EXPECTED(16'hF888)) dut2 (.clk(clk), .rst(rst), .sif(if2));

    assign if0.start = st[0];
    assign if1.start = st[1];
    assign if2.start = st[2];
    assign if0.abort = ab[0];
    assign if1.abort = ab[1];
    assign if2.abort = ab[2];
    assign if0.f_in  = flt ? 1'b0 : ((if0.a & if0.b) | (if0.c & if0.d));
    assign if1.f_in  = flt ? 1'b0 : ((if1.a & if1.b) | (if1.c & if1.d));
    assign if2.f_in  = flt ? 1'b0 : ((if2.a & if2.b) | (if2.c & if2.d));

    logic [3:0]  vec   [3];
    logic        busy  [3];
    logic        done  [3];
    logic        pass  [3];
    logic [4:0]  mcnt  [3];
    logic [3:0]  ffail [3];
    logic [15:0] tt    [3];

    assign vec[0]   = {if0.a, if0.b, if0.c, if0.d};
    assign vec[1]   = {if1.a, if1.b, if1.c, if1.d};
    assign vec[2]   = {if2.a, if2.b, if2.c, if2.d};
    assign busy[0]  = if0.busy;
    assign busy[1]  = if1.busy;
    assign busy[2]  = if2.busy;
    assign done[0]  = if0.done;
    assign done[1]  = if1.done;
    assign done[2]  = if2.done;
    assign pass[0]  = if0.pass;
    assign pass[1]  = if1.pass;
    assign pass[2]  = if2.pass;
    assign mcnt[0]  = if0.mismatch_cnt;
    assign mcnt[1]  = if1.mismatch_cnt;
    assign mcnt[2]  = if2.mismatch_cnt;
    assign ffail[0] = if0.first_fail;
    assign ffail[1] = if1.first_fail;
    assign ffail[2] = if2.first_fail;
    assign tt[0]    = if0.truth_table;
    assign tt[1]    = if1.truth_table;
    assign tt[2]    = if2.truth_table;

    typedef struct {
        int          sel;
        bit          fault;
        bit          ign;
        logic [15:0] tt;
        bit          pass;
        int          mc;
        int          ff;
        int          cyc;
    } row_t;

    row_t rows [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_zero(input int s, input string tag);
        chk({tag, "_vec"},   32'(vec[s]),   32'h0);
        chk({tag, "_busy"},  32'(busy[s]),  32'h0);
        chk({tag, "_done"},  32'(done[s]),  32'h0);
        chk({tag, "_pass"},  32'(pass[s]),  32'h0);
        chk({tag, "_mcnt"},  32'(mcnt[s]),  32'h0);
        chk({tag, "_ffail"}, 32'(ffail[s]), 32'h0);
        chk({tag, "_tt"},    32'(tt[s]),    32'h0);
    endtask

    initial begin
        int settle [3];
        int done_at;
        int dones;
        settle[0] = 2; settle[1] = 1; settle[2] = 5;
        for (int i = 0; i < 3; i++) begin st[i] = 1'b0; ab[i] = 1'b0; end

        //          sel fault ign  tt        pass mc ff cyc
        rows[0] = '{0,  1'b0, 1'b0, 16'hF888, 1'b1, 0, 0, 32};
        rows[1] = '{0,  1'b1, 1'b0, 16'h0000, 1'b0, 7, 3, 32};
        rows[2] = '{1,  1'b0, 1'b0, 16'hF888, 1'b1, 0, 0, 16};
        rows[3] = '{2,  1'b0, 1'b0, 16'hF888, 1'b1, 0, 0, 80};
        rows[4] = '{2,  1'b1, 1'b0, 16'h0000, 1'b0, 7, 3, 80};
        rows[5] = '{0,  1'b0, 1'b1, 16'hF888, 1'b1, 0, 0, 32};
        rows[6] = '{1,  1'b1, 1'b0, 16'h0000, 1'b0, 7, 3, 16};

        // Reset state, then idle for 20 cycles with start low
        #2;
        for (int s = 0; s < 3; s++) chk_idle_zero(s, "reset");
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                if (vec[s] !== 4'd0 || busy[s] !== 1'b0) begin
                    chk("idle_hold_vec_busy", {27'd0, busy[s], vec[s]}, 32'h0);
                end
            end
        end
        chk("idle_after20_busy0", 32'(busy[0]), 32'h0);

        // Abort during vector 6 with stuck-at-0 f_in
        flt = 1'b1;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_on_vec6", 32'(vec[0]), 32'd6);
        ab[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ab[0] = 1'b0;
        chk("abort_busy",  32'(busy[0]),  32'h0);
        chk("abort_vec",   32'(vec[0]),   32'h0);
        chk("abort_pass",  32'(pass[0]),  32'h0);
        chk("abort_done",  32'(done[0]),  32'h0);
        chk("abort_tt",    32'(tt[0]),    32'h0);
        chk("abort_mcnt",  32'(mcnt[0]),  32'd1);
        chk("abort_ffail", 32'(ffail[0]), 32'd3);
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) dones++;
        end
        chk("abort_no_done_after", 32'(dones), 32'd0);

        // start and abort together in IDLE: abort wins
        st[0] = 1'b1;
        ab[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        ab[0] = 1'b0;
        chk("start_abort_busy", 32'(busy[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("start_abort_vec", 32'(vec[0]), 32'h0);

        // Table-driven full sweeps
        for (int r = 0; r < 7; r++) begin
            int s;
            int sc;
            s  = rows[r].sel;
            sc = settle[s];
            flt = rows[r].fault;
            done_at = -1;
            dones   = 0;
            st[s] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            st[s] = 1'b0;
            chk($sformatf("r%0d_busy_start", r), 32'(busy[s]), 32'h1);
            chk($sformatf("r%0d_vec0", r), 32'(vec[s]), 32'h0);
            for (int n = 1; n <= 16 * sc + 3; n++) begin
                @(posedge clk);
                @(negedge clk);
                if (done[s] === 1'b1) begin
                    dones++;
                    if (done_at < 0) done_at = n;
                end
                if (n < 16 * sc && vec[s] !== 4'(n / sc))
                    chk($sformatf("r%0d_vec_n%0d", r, n), 32'(vec[s]), 32'(n / sc));
                if (n == 16 * sc) begin
                    chk($sformatf("r%0d_pass_at_done", r), 32'(pass[s]), 32'(rows[r].pass));
                    chk($sformatf("r%0d_vec_at_done", r), 32'(vec[s]), 32'h0);
                end
                st[s] = (rows[r].ign && (n == 5 || n == 20)) ? 1'b1 : 1'b0;
            end
            st[s] = 1'b0;
            chk($sformatf("r%0d_done_cycle", r), 32'(done_at), 32'(rows[r].cyc));
            chk($sformatf("r%0d_done_count", r), 32'(dones), 32'd1);
            chk($sformatf("r%0d_busy_end", r), 32'(busy[s]), 32'h0);
            chk($sformatf("r%0d_tt", r), 32'(tt[s]), 32'(rows[r].tt));
            chk($sformatf("r%0d_pass", r), 32'(pass[s]), 32'(rows[r].pass));
            chk($sformatf("r%0d_mcnt", r), 32'(mcnt[s]), 32'(rows[r].mc));
            chk($sformatf("r%0d_ffail", r), 32'(ffail[s]), 32'(rows[r].ff));
        end

        // Asynchronous reset mid-sweep, checked before the next clock edge
        flt = 1'b0;
        st[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[1] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midreset_pre_busy", 32'(busy[1]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_idle_zero(1, "midreset");
        chk_idle_zero(2, "midreset2");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_idle_busy", 32'(busy[1]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
